// File: rtl/wb_arb_pkg.sv
// Shared encodings and helpers for the Wishbone round-robin arbiter.
// Pure definitions; no latency or flow control of its own.
package wb_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    ABORT = ST_ABORT
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned MAX_MASTERS = 4;

  function automatic logic [1:0] onehot_to_index(input logic [MAX_MASTERS-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_MASTERS); i++) begin
      if (oh[i]) idx = idx | 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
// Zero latency; no backpressure, output is all-zero when nothing requests.
module rr_priority_pick #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [PW:0] slot;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    slot  = '0;
    for (int i = 0; i < N; i++) begin
      slot = {1'b0, ptr_i} + (PW+1)'(i);
      if (slot >= (PW+1)'(N)) slot = slot - (PW+1)'(N);
      if (!found && req_i[slot[PW-1:0]]) begin
        gnt_o[slot[PW-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin Wishbone classic arbiter: one grant per CYC burst, 1-cycle grant latency, 1 dead cycle per release.
// Losing masters stall with ACK/ERR low; a watchdog aborts stuck transfers with a 1-cycle ERR to the owner.
module wishbone_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
  output logic [DATA_W-1:0]             m_data_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        gnt_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [DATA_W-1:0]             s_data_o,
  input  logic [DATA_W-1:0]             s_data_i,
  input  logic                          s_ack_i
);

  localparam int PW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          gidx, gidx_next;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   in_grant, g_cyc, stall;

  rr_priority_pick #(.N(NUM_MASTERS)) u_pick (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  assign gidx      = PW'(onehot_to_index(MAX_MASTERS'(gnt_q)));
  assign gidx_next = (gidx == PW'(NUM_MASTERS - 1)) ? '0 : gidx + PW'(1);

  assign in_grant = (state_q == GRANT);
  assign g_cyc    = m_cyc_i[gidx];

  // Slave side is forced idle outside GRANT so an ABORT cycle really drops CYC.
  assign s_cyc_o  = in_grant & g_cyc;
  assign s_stb_o  = in_grant & m_stb_i[gidx];
  assign s_we_o   = in_grant & m_we_i[gidx];
  assign s_addr_o = in_grant ? m_addr_i[gidx*ADDR_W +: ADDR_W] : '0;
  assign s_data_o = in_grant ? m_data_i[gidx*DATA_W +: DATA_W] : '0;

  assign m_data_o = s_data_i;
  assign m_ack_o  = in_grant ? (gnt_q & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o  = (state_q == ABORT) ? gnt_q : '0;
  assign gnt_o    = gnt_q;

  assign stall = s_stb_o & ~s_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!g_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = gidx_next;
        end else if (stall) begin
          // An ACK in the final cycle clears stall, so ACK beats the timeout.
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) state_d = ABORT;
          else                                  cnt_d   = cnt_q + CW'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = gidx_next;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Scoreboarded bench for wishbone_arbiter: directed master traffic pushes expected responses,
// a negedge monitor pops one entry per ACK/ERR and compares routing, slave-side fields and read data.
module tb_wishbone_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;

  logic          mc[N];
  logic          ms[N];
  logic          mw[N];
  logic [AW-1:0] ma[N];
  logic [DW-1:0] md[N];

  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_addr_i;
  logic [N*DW-1:0] m_data_i;
  logic [DW-1:0]   m_data_o;
  logic [N-1:0]    m_ack_o, m_err_o, gnt_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_data_o, s_data_i;
  logic            s_ack_i;

  assign m_cyc_i  = {mc[1], mc[0]};
  assign m_stb_i  = {ms[1], ms[0]};
  assign m_we_i   = {mw[1], mw[0]};
  assign m_addr_i = {ma[1], ma[0]};
  assign m_data_i = {md[1], md[0]};

  wishbone_arbiter #(
    .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .gnt_o(gnt_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  // Slave model: ACK after ack_lat extra wait cycles, read data derived from the address.
  logic ack_en;
  int   ack_lat;
  int   wcnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_i <= 1'b0;
      wcnt    <= 0;
    end else if (s_cyc_o && s_stb_o && !s_ack_i && ack_en) begin
      if (wcnt >= ack_lat) begin
        s_ack_i <= 1'b1;
        wcnt    <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      s_ack_i <= 1'b0;
      wcnt    <= 0;
    end
  end

  assign s_data_i = s_addr_o ^ 32'hDEAD_BEEF;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]  ack;
    logic [N-1:0]  err;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  function automatic void push(input logic [N-1:0] ack, input logic [N-1:0] err,
                               input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    exp_q.push_back('{ack, err, a, w, d});
  endfunction

  int   cyc_cnt = 0;
  int   stb_start = 0;
  int   last_resp = 0;
  logic stb_prev = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rst) begin
      stb_prev <= 1'b0;
    end else begin
      if (s_stb_o && !stb_prev) stb_start <= cyc_cnt;
      stb_prev <= s_stb_o;
      if (m_ack_o != '0 || m_err_o != '0) begin
        last_resp <= cyc_cnt;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {m_ack_o, m_err_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_ack", m_ack_o, e.ack);
          chk("resp_err", m_err_o, e.err);
          if (e.err != '0) begin
            chk("abort_s_cyc", s_cyc_o, 1'b0);
          end else begin
            chk("s_addr", s_addr_o, e.addr);
            chk("s_we", s_we_o, e.we);
            chk("s_wdata", s_data_o, e.wdata);
            chk("m_rdata", m_data_o, e.addr ^ 32'hDEAD_BEEF);
          end
        end
      end
    end
  end

  // One Wishbone cycle of 'beats' back-to-back beats; an ERR ends the cycle early.
  task automatic xfer(input int k, input logic w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input int beats);
    int   waited;
    logic got_err;
    mc[k] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      ms[k] = 1'b1;
      mw[k] = w;
      ma[k] = a + AW'(4 * b);
      md[k] = d + DW'(b);
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(m_ack_o[k] || m_err_o[k]) && waited < 200);
      got_err = m_err_o[k];
      if (!(m_ack_o[k] || m_err_o[k])) begin
        errors++;
        $display("FAIL xfer_wait: master %0d got no ACK/ERR in %0d cycles, required a response", k, waited);
      end
      @(posedge clk);
      #1;
      if (got_err) break;
    end
    mc[k] = 1'b0;
    ms[k] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: run did not complete, required completion");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int w;
    rst     = 1'b1;
    ack_en  = 1'b1;
    ack_lat = 0;
    for (int k = 0; k < N; k++) begin
      mc[k] = 1'b0; ms[k] = 1'b0; mw[k] = 1'b0; ma[k] = '0; md[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_ack", m_ack_o, 0);
    chk("rst_err", m_err_o, 0);
    chk("rst_s_addr", s_addr_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single write from master 0, with grant latency and release timing.
    push(2'b01, 2'b00, 32'h10, 1'b1, 32'hA5);
    fork
      xfer(0, 1'b1, 32'h10, 32'hA5, 1);
      begin
        @(negedge clk);
        chk("lat_idle_s_cyc", s_cyc_o, 0);
        @(negedge clk);
        chk("lat_s_cyc", s_cyc_o, 1);
        chk("lat_gnt", gnt_o, 2'b01);
      end
    join
    @(negedge clk);
    chk("release_gnt", gnt_o, 2'b00);
    @(posedge clk); #1;

    // Contention: pointer now favours master 1, then strict alternation.
    push(2'b10, 2'b00, 32'h100, 1'b0, 32'h21);
    push(2'b01, 2'b00, 32'h200, 1'b1, 32'h11);
    push(2'b10, 2'b00, 32'h104, 1'b0, 32'h22);
    push(2'b01, 2'b00, 32'h204, 1'b1, 32'h12);
    fork
      begin xfer(0, 1'b1, 32'h200, 32'h11, 1); xfer(0, 1'b1, 32'h204, 32'h12, 1); end
      begin xfer(1, 1'b0, 32'h100, 32'h21, 1); xfer(1, 1'b0, 32'h104, 32'h22, 1); end
    join

    // Multi-beat burst by master 1 is not interrupted by master 0.
    for (int b = 0; b < 4; b++)
      push(2'b10, 2'b00, 32'h300 + 32'(4 * b), 1'b1, 32'h31 + 32'(b));
    push(2'b01, 2'b00, 32'h400, 1'b0, 32'h41);
    fork
      xfer(1, 1'b1, 32'h300, 32'h31, 4);
      begin repeat (2) @(posedge clk); #1; xfer(0, 1'b0, 32'h400, 32'h41, 1); end
    join

    // Watchdog abort on master 1.
    ack_en = 1'b0;
    push(2'b00, 2'b10, 32'h500, 1'b0, 32'h0);
    xfer(1, 1'b0, 32'h500, 32'h0, 1);
    ack_en = 1'b1;
    chk("timeout_cycles", last_resp - stb_start, 8);

    // Pointer moved past master 1, so master 0 wins the tie.
    push(2'b01, 2'b00, 32'h600, 1'b1, 32'h61);
    push(2'b10, 2'b00, 32'h700, 1'b1, 32'h71);
    fork
      xfer(0, 1'b1, 32'h600, 32'h61, 1);
      xfer(1, 1'b1, 32'h700, 32'h71, 1);
    join

    // ACK in the last watchdog cycle wins over ERR.
    ack_lat = 6;
    push(2'b01, 2'b00, 32'h800, 1'b1, 32'h81);
    xfer(0, 1'b1, 32'h800, 32'h81, 1);
    ack_lat = 0;
    chk("ack_final_cycles", last_resp - stb_start, 7);

    // Asynchronous reset in the middle of a granted transfer.
    ack_en = 1'b0;
    mc[0] = 1'b1; ms[0] = 1'b1; mw[0] = 1'b1; ma[0] = 32'h900; md[0] = 32'h91;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (gnt_o != 2'b01 && w < 20);
    chk("rst_mid_pre_gnt", gnt_o, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_s_cyc", s_cyc_o, 0);
    chk("rst_mid_gnt", gnt_o, 0);
    chk("rst_mid_ack", m_ack_o, 0);
    mc[0] = 1'b0; ms[0] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    ack_en = 1'b1;
    @(posedge clk); #1;

    // After reset master 0 has priority again.
    push(2'b01, 2'b00, 32'hA00, 1'b0, 32'hA1);
    push(2'b10, 2'b00, 32'hB00, 1'b0, 32'hB1);
    fork
      xfer(0, 1'b0, 32'hA00, 32'hA1, 1);
      xfer(1, 1'b0, 32'hB00, 32'hB1, 1);
    join

    repeat (3) @(posedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
